mmu_result_collector: RTL and testbench

//  Sits directly downstream of the 2x2 systolic MMU and consumes its acc_out1/acc_out2 column outputs.

---
 rtl/tpu_pkg.sv | 24 ++
 rtl/mmu_result_collector_col_deskew.sv | 42 ++++
 rtl/mmu_result_collector.sv | 156 +++++++++++++++
 tb/tb_mmu_result_collector.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// ----------------------------------------------------------------------------
// tpu_pkg
//   Shared types and constants for the TPU datapath blocks.
//
//   DEFAULT_DATA_W   default width of one accumulated result element
//   collect_state_t  result-collector FSM states {IDLE, COLLECT, DRAIN}
//   row_t            one drained result row {col1, col0} at the default width
// ----------------------------------------------------------------------------
package tpu_pkg;

    localparam int DEFAULT_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } collect_state_t;

    typedef struct packed {
        logic [DEFAULT_DATA_W-1:0] col1;
        logic [DEFAULT_DATA_W-1:0] col0;
    } row_t;

endpackage

// File: rtl/mmu_result_collector_col_deskew.sv
// ----------------------------------------------------------------------------
// mmu_result_collector_col_deskew
//   The MMU delivers column 1 one cycle after column 0. This block delays the
//   column-0 capture strobe and its row index by one cycle so the parent can
//   write column 1 into the same matrix row.
//
//   Parameters
//     RW        width of the row index
//   Ports
//     clk       clock, rising edge
//     reset     asynchronous, active-low reset
//     cap_en    column-0 element accepted this cycle
//     cap_row   row index the column-0 element was written to
//     col1_we   column-1 element present this cycle (write enable)
//     col1_row  row index for the column-1 write
// ----------------------------------------------------------------------------
module mmu_result_collector_col_deskew #(
    parameter int RW = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cap_en,
    input  logic [RW-1:0] cap_row,
    output logic          col1_we,
    output logic [RW-1:0] col1_row
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col1_we  <= 1'b0;
            col1_row <= '0;
        end else begin
            col1_we <= cap_en;
            if (cap_en) begin
                col1_row <= cap_row;
            end
        end
    end

endmodule

// File: rtl/mmu_result_collector.sv
// ----------------------------------------------------------------------------
// mmu_result_collector
//   Consumes the 2-column output of the 2x2 systolic MMU, de-skews column 1
//   (which lags column 0 by one cycle), stores ROWS result rows and then
//   drains them row by row over a valid/ready handshake.
//
//   Build option: define MMU_COLLECT_RELU_EN to clamp negative elements to 0
//   at capture time. Timing is identical with or without it.
//
//   Parameters
//     DATA_W     element width (stored verbatim, two's complement)
//     ROWS       rows per matrix (1..16)
//   Ports
//     clk        clock, rising edge
//     reset      asynchronous, active-low reset
//     acc_valid  acc_col0 valid this cycle; matching acc_col1 arrives next cycle
//     acc_col0   MMU column 0 element
//     acc_col1   MMU column 1 element
//     out_valid  out_row holds a stored row (high throughout DRAIN)
//     out_ready  consumer accepts out_row when out_valid && out_ready
//     out_row    {col1, col0} of the current drain row
//     out_last   current drain row is the final row
//     busy       FSM not idle
//     done       one-cycle pulse after the final row is accepted
//     overflow   sticky: input arrived while it could not be accepted
// ----------------------------------------------------------------------------
module mmu_result_collector
    import tpu_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ROWS   = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                acc_valid,
    input  logic [DATA_W-1:0]   acc_col0,
    input  logic [DATA_W-1:0]   acc_col1,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*DATA_W-1:0] out_row,
    output logic                out_last,
    output logic                busy,
    output logic                done,
    output logic                overflow
);

    localparam int            RW       = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    collect_state_t    state;
    logic [RW-1:0]     wr_row;
    logic [RW-1:0]     rd_row;
    logic [DATA_W-1:0] mat_col0 [ROWS];
    logic [DATA_W-1:0] mat_col1 [ROWS];

    logic              col1_pend;
    logic [RW-1:0]     col1_row;
    logic              last_col1;
    logic              cap_en;
    logic              drain_hs;
    logic              drain_end;
    logic [DATA_W-1:0] col0_in;
    logic [DATA_W-1:0] col1_in;

    // Column 1 write strobe/address: the column-0 capture delayed by one cycle.
    mmu_result_collector_col_deskew #(
        .RW (RW)
    ) u_deskew (
        .clk      (clk),
        .reset    (reset),
        .cap_en   (cap_en),
        .cap_row  (wr_row),
        .col1_we  (col1_pend),
        .col1_row (col1_row)
    );

    // NOTE: every signal driven here gets a value on every path, so no
    // latch is inferred.
    always_comb begin
        col0_in = acc_col0;
        col1_in = acc_col1;
`ifdef MMU_COLLECT_RELU_EN
        if (acc_col0[DATA_W-1]) col0_in = '0;
        if (acc_col1[DATA_W-1]) col1_in = '0;
`endif
    end

    always_comb begin
        // The final row's column 1 completes the matrix; a new column-0
        // element in that same cycle has no row to go to.
        last_col1 = col1_pend && (col1_row == LAST_ROW);
        cap_en    = acc_valid && (state != DRAIN) && !last_col1;
        drain_hs  = (state == DRAIN) && out_ready;
        drain_end = drain_hs && (rd_row == LAST_ROW);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            wr_row   <= '0;
            rd_row   <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= drain_end;
            if (acc_valid && !cap_en) begin
                overflow <= 1'b1;
            end

            unique case (state)
                IDLE:    if (cap_en)    state <= COLLECT;
                COLLECT: if (last_col1) state <= DRAIN;
                DRAIN:   if (drain_end) state <= IDLE;
                default:                state <= IDLE;
            endcase

            // wr_row tracks column 0 and wraps after the final row, so it is
            // already 0 when the FSM enters DRAIN.
            if (cap_en) begin
                wr_row <= (wr_row == LAST_ROW) ? '0 : wr_row + RW'(1);
            end
            if (drain_hs) begin
                rd_row <= (rd_row == LAST_ROW) ? '0 : rd_row + RW'(1);
            end
        end
    end

    // NOTE: the matrix is reset explicitly so a drained row can never expose
    // stale data from an aborted collection; this keeps it out of RAM macros.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < ROWS; r++) begin
                mat_col0[r] <= '0;
                mat_col1[r] <= '0;
            end
        end else begin
            // Back-to-back input writes col0 of row k+1 and col1 of row k in
            // the same cycle; they target different arrays.
            if (cap_en) begin
                mat_col0[wr_row] <= col0_in;
            end
            if (col1_pend) begin
                mat_col1[col1_row] <= col1_in;
            end
        end
    end

    // Outputs are gated by DRAIN so nothing is visible outside a drain.
    always_comb begin
        out_valid = (state == DRAIN);
        out_row   = out_valid ? {mat_col1[rd_row], mat_col0[rd_row]} : '0;
        out_last  = out_valid && (rd_row == LAST_ROW);
        busy      = (state != IDLE);
    end

endmodule

// File: tb/tb_mmu_result_collector.sv
// ----------------------------------------------------------------------------
// tb_mmu_result_collector
//   Self-checking bench for mmu_result_collector (DATA_W=8, ROWS=2).
//   Expected rows are queued as stimulus is driven and popped on each drain
//   handshake. Define MMU_COLLECT_RELU_EN for both bench and RTL together.
// ----------------------------------------------------------------------------
module tb_mmu_result_collector;
    import tpu_pkg::*;

    localparam int DW   = DEFAULT_DATA_W;
    localparam int ROWS = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          acc_valid;
    logic [DW-1:0] acc_col0;
    logic [DW-1:0] acc_col1;
    logic          out_valid;
    logic          out_ready;
    logic [2*DW-1:0] out_row;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          overflow;

    int vectors     = 0;
    int miscompares = 0;

    row_t          exp_q [$];
    logic [DW-1:0] s_c0 [ROWS];
    logic [DW-1:0] s_c1 [ROWS];

    mmu_result_collector #(
        .DATA_W (DW),
        .ROWS   (ROWS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .acc_valid (acc_valid),
        .acc_col0  (acc_col0),
        .acc_col1  (acc_col1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] relu(input logic [DW-1:0] x);
`ifdef MMU_COLLECT_RELU_EN
        return x[DW-1] ? '0 : x;
`else
        return x;
`endif
    endfunction

    // Drive one matrix: acc_valid every 'gap' cycles, col1 one cycle later.
    // 'collide' adds an acc_valid on the final col1 cycle, which must be dropped.
    task automatic feed(input int gap, input logic chk_busy, input logic collide);
        int last_c;
        last_c = (ROWS - 1) * gap + 1;
        for (int c = 0; c <= last_c; c++) begin
            @(negedge clk);
            if (chk_busy) begin
                vectors++;
                if (busy !== (c >= 1))
                    $display("FAIL busy_collect c=%0d: got %b expected %b", c, busy, (c >= 1));
            end
            if (chk_busy && busy !== (c >= 1)) miscompares++;
            if ((c % gap == 0) && (c / gap < ROWS)) begin
                acc_valid = 1'b1;
                acc_col0  = s_c0[c / gap];
            end else begin
                acc_valid = 1'b0;
                acc_col0  = 8'hAA;
            end
            if ((c >= 1) && ((c - 1) % gap == 0) && ((c - 1) / gap < ROWS)) begin
                acc_col1 = s_c1[(c - 1) / gap];
                exp_q.push_back('{col1: relu(s_c1[(c - 1) / gap]),
                                  col0: relu(s_c0[(c - 1) / gap])});
            end else begin
                acc_col1 = 8'hBB;
            end
            if (collide && c == last_c) begin
                acc_valid = 1'b1;
                acc_col0  = 8'h55;
            end
        end
        @(negedge clk);
        acc_valid = 1'b0;
        acc_col0  = 8'hAA;
        acc_col1  = 8'hBB;
    endtask

    // Drain all queued rows; ready held low for 'stall' valid cycles and an
    // acc_valid (col0=9) injected on valid cycle 'inject' (-1 = none).
    task automatic drain(input int stall, input int inject);
        int   cyc;
        int   waited;
        row_t e;
        cyc    = 0;
        waited = 0;
        while (exp_q.size() > 0) begin
            if (waited > 40) begin
                vectors++;
                miscompares++;
                $display("FAIL drain_timeout: got out_valid=%b, expected 1 within 40 cycles", out_valid);
                exp_q.delete();
                break;
            end
            if (!out_valid) begin
                if (cyc > 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL valid_drop: got out_valid=0 mid-drain, expected 1");
                end
                waited++;
                out_ready = 1'b0;
                acc_valid = 1'b0;
            end else begin
                e = exp_q[0];
                vectors++;
                if (out_row !== e) begin
                    miscompares++;
                    $display("FAIL out_row cyc=%0d: got %h expected %h", cyc, out_row, e);
                end
                acc_valid = (cyc == inject);
                acc_col0  = (cyc == inject) ? 8'h09 : 8'hAA;
                out_ready = (cyc >= stall);
                if (out_ready) begin
                    vectors++;
                    if (out_last !== (exp_q.size() == 1)) begin
                        miscompares++;
                        $display("FAIL out_last: got %b expected %b", out_last, (exp_q.size() == 1));
                    end
                    void'(exp_q.pop_front());
                end
                cyc++;
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        acc_valid = 1'b0;
        acc_col0  = 8'hAA;
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse: got done=%b busy=%b out_valid=%b expected 1 0 0", done, busy, out_valid);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL done_width: got done=%b expected 0", done);
        end
    endtask

    task automatic check_all_zero(input string tag);
        vectors++;
        if ({out_valid, out_row, out_last, busy, done, overflow} !== '0) begin
            miscompares++;
            $display("FAIL %s: got valid=%b row=%h last=%b busy=%b done=%b ovf=%b expected all 0",
                     tag, out_valid, out_row, out_last, busy, done, overflow);
        end
    endtask

    task automatic set_matrix(input logic [DW-1:0] a0, input logic [DW-1:0] a1,
                              input logic [DW-1:0] b0, input logic [DW-1:0] b1);
        s_c0[0] = a0; s_c1[0] = a1;
        s_c0[1] = b0; s_c1[1] = b1;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        acc_valid = 1'b1;
        acc_col0  = 8'h12;
        acc_col1  = 8'h34;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_all_zero("reset_hold");
        end
        acc_valid = 1'b0;
        out_ready = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        check_all_zero("reset_release");
    endtask

    task automatic test_basic();
        set_matrix(8'd3, 8'd4, 8'd7, 8'd8);
        out_ready = 1'b1;  // ignored outside DRAIN
        feed(1, 1'b0, 1'b0);
        drain(0, -1);
    endtask

    task automatic test_stall();
        set_matrix(8'd3, 8'd4, 8'd7, 8'd8);
        feed(1, 1'b0, 1'b0);
        drain(3, -1);
    endtask

    task automatic test_spaced();
        set_matrix(8'd3, 8'd4, 8'd7, 8'd8);
        feed(4, 1'b1, 1'b0);
        drain(0, -1);
    endtask

    task automatic test_random();
        for (int m = 0; m < 3; m++) begin
            for (int r = 0; r < ROWS; r++) begin
                s_c0[r] = DW'($urandom);
                s_c1[r] = DW'($urandom);
            end
            feed($urandom_range(1, 3), 1'b0, 1'b0);
            drain($urandom_range(0, 2), -1);
        end
    endtask

    task automatic test_relu();
        set_matrix(8'hF0, 8'd5, 8'h81, 8'h7F);
        feed(1, 1'b0, 1'b0);
        drain(0, -1);
    endtask

    task automatic test_overflow();
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL overflow_pre: got %b expected 0", overflow);
        end
        set_matrix(8'd21, 8'd22, 8'd23, 8'd24);
        feed(1, 1'b0, 1'b0);
        drain(1, 0);
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_set: got %b expected 1", overflow);
        end
        set_matrix(8'd41, 8'd42, 8'd43, 8'd44);
        feed(2, 1'b0, 1'b0);
        drain(0, -1);
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_sticky: got %b expected 1", overflow);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        acc_valid = 1'b1;
        acc_col0  = 8'd51;
        @(negedge clk);
        acc_valid = 1'b0;
        acc_col1  = 8'd52;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_mid: got %b expected 1", busy);
        end
        reset = 1'b0;
        #1;
        check_all_zero("reset_async");
        @(negedge clk);
        check_all_zero("reset_mid_hold");
        reset = 1'b1;
        set_matrix(8'd31, 8'd32, 8'd33, 8'd34);
        feed(1, 1'b0, 1'b0);
        drain(0, -1);
    endtask

    task automatic test_collide();
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL collide_pre: got overflow=%b expected 0", overflow);
        end
        set_matrix(8'd61, 8'd62, 8'd63, 8'd64);
        feed(1, 1'b0, 1'b1);
        drain(0, -1);
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL collide_overflow: got %b expected 1", overflow);
        end
    endtask

    initial begin
        acc_valid = 1'b0;
        acc_col0  = '0;
        acc_col1  = '0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_spaced();
        test_random();
        test_relu();
        test_overflow();
        test_reset_mid();
        test_collide();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
